// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states,
// and the request legality rule used at accept time.
package lsu_pkg;

    localparam int MEM_WORDS_DEF = 4096;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_ADDR  = 3'd1,
        S_LD_DATA  = 3'd2,
        S_RMW_ADDR = 3'd3,
        S_RMW_DATA = 3'd4,
        S_ST_WR    = 3'd5
    } state_t;

    // Unsigned variants have no store form; halves need even, words need 4-byte alignment.
    function automatic logic lsu_fault(input logic store, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    lsu_fault = 1'b0;
            F3_H:    lsu_fault = addr_lo[0];
            F3_W:    lsu_fault = (addr_lo != 2'b00);
            F3_BU:   lsu_fault = store;
            F3_HU:   lsu_fault = store | addr_lo[0];
            default: lsu_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling: pulls a byte/half out of a memory word with sign/zero extension,
// and merges store data into a read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unused_wdata;

    assign w_unused_wdata = ^i_wdata[31:16];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    always_comb begin
        o_load = '0;
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_W:    o_load = i_rdata;
            F3_BU:   o_load = {24'b0, w_byte};
            F3_HU:   o_load = {16'b0, w_half};
            default: o_load = '0;
        endcase
    end

    always_comb begin
        o_merge = i_rdata;
        case (i_funct3)
            F3_B:    o_merge[{i_off, 3'b000} +: 8]      = i_wdata[7:0];
            F3_H:    o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time against a registered-read word memory;
// sub-word stores are done as read-modify-write.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_fault_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [2:0]  dbg_state_o
);

    localparam int AW = $clog2(MEM_WORDS);

    // Handshake: a request transfers on a cycle where req_valid_i && req_ready_o; request
    // inputs are ignored at all other times. rsp_valid_o is a one-cycle pulse with no backpressure.
    state_t          r_state, w_next;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [AW-1:0]   r_word_idx;
    logic [31:0]     r_mem_wdata, r_rsp_rdata;
    logic            r_rsp_valid, r_rsp_fault;
    logic            w_fault, w_unused_addr;
    logic [31:0]     w_load, w_merge;

    assign w_fault       = lsu_fault(req_store_i, req_funct3_i, req_addr_i[1:0]);
    assign w_unused_addr = ^req_addr_i[31:AW+2];

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_rdata  (mem_rdata_i),
        .i_wdata  (r_mem_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i && !w_fault) begin
                    if (!req_store_i)              w_next = S_LD_ADDR;
                    else if (req_funct3_i == F3_W) w_next = S_ST_WR;
                    else                           w_next = S_RMW_ADDR;
                end
            end
            S_LD_ADDR:  w_next = S_LD_DATA;
            S_LD_DATA:  w_next = S_IDLE;
            S_RMW_ADDR: w_next = S_RMW_DATA;
            S_RMW_DATA: w_next = S_ST_WR;
            S_ST_WR:    w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Responses are registered so they land in the same cycle the FSM is back in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_funct3    <= '0;
            r_off       <= '0;
            r_word_idx  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (w_fault) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_fault <= 1'b1;
                        end else begin
                            r_funct3   <= req_funct3_i;
                            r_off      <= req_addr_i[1:0];
                            r_word_idx <= req_addr_i[AW+1:2];
                            if (req_store_i) r_mem_wdata <= req_wdata_i;
                        end
                    end
                end
                S_LD_DATA: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_load;
                end
                S_RMW_DATA: r_mem_wdata <= w_merge;
                S_ST_WR:    r_rsp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // The write strobe is gated by reset so an aborted store never reaches memory.
    assign mem_write_o = (r_state == S_ST_WR) && !rst_i;
    assign mem_addr_o  = {{(32-AW){1'b0}}, r_word_idx};
    assign mem_wdata_o = r_mem_wdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_fault_o = r_rsp_fault;
    assign rsp_rdata_o = r_rsp_rdata;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: word memory behind the DUT, a request-level reference model,
// a per-cycle compare process, directed pins and a randomized request stream.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_store_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_fault_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic [2:0]  dbg_state;

    lsu_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_store_i  (req_store_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_fault_o  (rsp_fault_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory behind the DUT ----------------
    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    int wr_count = 0;

    always @(posedge clk) begin
        if (mem_write_o) begin
            mem[mem_addr_o[11:0]] <= mem_wdata_o;
            wr_count <= wr_count + 1;
        end
        mem_rdata_i <= mem[mem_addr_o[11:0]];
    end

    // ---------------- scoreboard ----------------
    typedef struct { int cyc; logic [31:0] data; logic fault; } rsp_t;
    typedef struct { int cyc; logic [31:0] idx; logic [31:0] data; } wr_t;
    rsp_t exp_rsp_q[$];
    wr_t  exp_wr_q[$];
    int   busy_until = 0;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_rsp_cyc = -1;
    logic [31:0] last_rsp_data = '0;
    logic        last_rsp_fault = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Request-level model: decides legality, latency, result and memory effect from the ISA rules.
    task automatic model_accept(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input int a);
        logic [31:0] idx, word, v, mask, nw;
        int   sh, sh16, lat;
        logic ok;
        rsp_t r;
        wr_t  w;
        idx  = (addr >> 2) % 4096;
        word = ref_mem[idx[11:0]];
        sh   = 8 * int'(addr % 4);
        sh16 = 16 * int'((addr / 2) % 2);
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (addr % 2 == 0);
            3'd2:    ok = (addr % 4 == 0);
            3'd4:    ok = !st;
            3'd5:    ok = !st && (addr % 2 == 0);
            default: ok = 1'b0;
        endcase
        r.fault = !ok;
        r.data  = 32'd0;
        if (!ok) begin
            lat = 1;
        end else if (!st) begin
            lat = 3;
            case (f3)
                3'd0: begin v = (word >> sh) & 32'hFF;     if (v >= 128)   v = v - 256;   end
                3'd1: begin v = (word >> sh16) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
                3'd4: v = (word >> sh) & 32'hFF;
                3'd5: v = (word >> sh16) & 32'hFFFF;
                default: v = word;
            endcase
            r.data = v;
        end else begin
            if (f3 == 3'd2) begin
                lat = 2;
                nw  = wd;
            end else if (f3 == 3'd0) begin
                lat  = 4;
                mask = 32'hFF << sh;
                nw   = (word & ~mask) | ((wd & 32'hFF) << sh);
            end else begin
                lat  = 4;
                mask = 32'hFFFF << sh16;
                nw   = (word & ~mask) | ((wd & 32'hFFFF) << sh16);
            end
            w.cyc  = a + lat - 1;
            w.idx  = idx;
            w.data = nw;
            exp_wr_q.push_back(w);
            ref_mem[idx[11:0]] = nw;
        end
        r.cyc = a + lat;
        exp_rsp_q.push_back(r);
        busy_until = a + lat;
    endtask

    // Compare process: every cycle after reset, outputs against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_rsp_q.size() > 0 && exp_rsp_q[0].cyc == cyc) begin
                chk("rsp_valid", rsp_valid_o, 1);
                chk("rsp_rdata", rsp_rdata_o, exp_rsp_q[0].data);
                chk("rsp_fault", rsp_fault_o, exp_rsp_q[0].fault);
                void'(exp_rsp_q.pop_front());
            end else begin
                chk("rsp_idle", rsp_valid_o, 0);
            end
            if (exp_wr_q.size() > 0 && exp_wr_q[0].cyc == cyc) begin
                chk("wr_strobe", mem_write_o, 1);
                chk("wr_addr", mem_addr_o, exp_wr_q[0].idx);
                chk("wr_data", mem_wdata_o, exp_wr_q[0].data);
                void'(exp_wr_q.pop_front());
            end else begin
                chk("wr_idle", mem_write_o, 0);
            end
            chk("ready", req_ready_o, (cyc >= busy_until) ? 1 : 0);
        end
        if (rsp_valid_o) begin
            last_rsp_cyc   = cyc;
            last_rsp_data  = rsp_rdata_o;
            last_rsp_fault = rsp_fault_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble();
        req_store_i  = 1'($urandom_range(0, 1));
        req_funct3_i = 3'($urandom_range(0, 7));
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, output int acc);
        @(negedge clk); #2;
        req_valid_i  = 1'b1;
        req_store_i  = st;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready_o) begin
                acc = cyc;
                model_accept(st, f3, addr, wd, acc);
                break;
            end
            @(negedge clk); #2;
        end
        if (acc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
        end
        @(posedge clk); #1;
        if (!hold) begin
            req_valid_i = 1'b0;
            scramble();
        end
    endtask

    task automatic expect_rsp(input string nm, input int acc, input int lat,
                              input logic [31:0] data, input logic fault);
        repeat (lat + 1) @(negedge clk);
        chk({nm, "_cycle"}, last_rsp_cyc, acc + lat);
        chk({nm, "_data"}, last_rsp_data, data);
        chk({nm, "_fault"}, last_rsp_fault, fault);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int a, a2, w0;
        logic [31:0] saved;
        bit hold;
        logic [2:0] f3;
        logic [31:0] addr;
        logic [2:0] legal [5];

        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = $urandom;
        end
        mem[0] = 32'h8070_F0A5;
        mem[1] = 32'h1122_3344;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = mem[i];
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", req_ready_o, 1);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_rdata", rsp_rdata_o, 0);
        chk("reset_rsp_fault", rsp_fault_o, 0);
        chk("reset_mem_write", mem_write_o, 0);
        chk("reset_mem_addr", mem_addr_o, 0);
        chk("reset_mem_wdata", mem_wdata_o, 0);
        #2 rst_i = 1'b0;
        chk_en = 1'b1;

        // Loads from word 0.
        issue(0, 3'd0, 32'h0, 32'h0, 0, a);
        expect_rsp("lb_0", a, 3, 32'hFFFF_FFA5, 0);
        issue(0, 3'd4, 32'h3, 32'h0, 0, a);
        expect_rsp("lbu_3", a, 3, 32'h0000_0080, 0);
        issue(0, 3'd1, 32'h2, 32'h0, 0, a);
        expect_rsp("lh_2", a, 3, 32'hFFFF_8070, 0);

        // Byte store via read-modify-write.
        w0 = wr_count;
        issue(1, 3'd0, 32'h5, 32'h0000_00AB, 0, a);
        expect_rsp("sb_5", a, 4, 32'h0, 0);
        chk("sb_one_write", wr_count - w0, 1);
        chk("sb_word1", mem[1], 32'h1122_AB44);

        // Misaligned requests fault without touching memory.
        w0 = wr_count;
        issue(0, 3'd2, 32'h2, 32'h0, 0, a);
        expect_rsp("lw_2_fault", a, 1, 32'h0, 1);
        issue(1, 3'd1, 32'h7, 32'h1234, 0, a);
        expect_rsp("sh_7_fault", a, 1, 32'h0, 1);
        chk("fault_no_write", wr_count - w0, 0);

        // Upper address bits wrap.
        issue(1, 3'd2, 32'h0000_4008, 32'hDEAD_BEEF, 0, a);
        expect_rsp("sw_4008", a, 2, 32'h0, 0);
        chk("sw_wrap_word2", mem[2], 32'hDEAD_BEEF);
        issue(0, 3'd2, 32'h8, 32'h0, 0, a);
        expect_rsp("lw_8", a, 3, 32'hDEAD_BEEF, 0);

        // Back-to-back with valid held across the response cycle.
        issue(1, 3'd2, 32'h10, 32'hCAFE_F00D, 1, a);
        issue(0, 3'd2, 32'h10, 32'h0, 0, a2);
        chk("b2b_accept_cycle", a2, a + 2);
        expect_rsp("b2b_lw", a2, 3, 32'hCAFE_F00D, 0);

        // Reset during RMW_DATA of a half store.
        saved = ref_mem[1];
        w0 = wr_count;
        issue(1, 3'd1, 32'h6, 32'h5555, 0, a);
        @(negedge clk);
        @(negedge clk); #2;
        rst_i = 1'b1;
        exp_rsp_q.delete();
        exp_wr_q.delete();
        ref_mem[1] = saved;
        busy_until = cyc + 1;
        @(negedge clk);
        chk("abort_rmw_ready", req_ready_o, 1);
        chk("abort_rmw_no_rsp", rsp_valid_o, 0);
        #2 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_rmw_no_write", wr_count - w0, 0);
        chk("abort_rmw_word1", mem[1], saved);

        // Reset while the word write is on the bus.
        saved = ref_mem[3];
        issue(1, 3'd2, 32'hC, 32'h0BAD_0BAD, 0, a);
        rst_i = 1'b1;
        exp_rsp_q.delete();
        exp_wr_q.delete();
        ref_mem[3] = saved;
        busy_until = cyc + 1;
        #1;
        chk("abort_st_wr_gate", mem_write_o, 0);
        @(negedge clk);
        @(negedge clk); #2;
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_st_word3", mem[3], saved);

        // Randomized stream over a small window of words so loads see earlier stores.
        for (int i = 0; i < 250; i++) begin
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = legal[$urandom_range(0, 4)];
            addr = ($urandom & 32'hFFFF_C000) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 1) == 1) addr = addr | $urandom_range(0, 3);
            hold = ($urandom_range(0, 2) == 0);
            issue(1'($urandom_range(0, 1)), f3, addr, $urandom, hold, a);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid_i = 1'b0;

        repeat (10) @(negedge clk);
        chk("rsp_queue_drained", exp_rsp_q.size(), 0);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        for (int i = 0; i < 20; i++) begin
            chk("final_mem_window", mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, number of 32-bit words in the data memory (word index width = log2(MEM_WORDS) = 12).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid_i  input  1  pipeline presents a load/store request.
REQ-005 SHALL have port req_ready_o  output  1  LSU can accept a request (IDLE only).
REQ-006 SHALL have port req_store_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3_i  input  3  RV32I width code (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010).
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data, lane-0 aligned.
REQ-010 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata_o  output  32  extended load result; 0 for stores and faults.
REQ-012 SHALL have port rsp_fault_o  output  1  misaligned or illegal funct3; valid with rsp_valid_o.
REQ-013 SHALL have port mem_write_o  output  1  data-memory write strobe.
REQ-014 SHALL have port mem_addr_o  output  32  word index, {20'b0, addr[13:2]}.
REQ-015 SHALL have port mem_wdata_o  output  32  full-word write data.
REQ-016 SHALL have port mem_rdata_i  input  32  memory read data, registered; valid the cycle after mem_addr_o is presented with mem_write_o=0.

Function
REQ-017 SHALL capture the request only on req_valid_i & req_ready_o; inputs are don't-care afterwards.
REQ-018 SHALL implement FSM states IDLE, LD_ADDR, LD_DATA, RMW_ADDR, RMW_DATA, ST_WR; req_ready_o=1 only in IDLE.
REQ-019 SHALL fault on: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 011/110/111, or 100/101 with store; fault: no memory access, rsp_valid_o=1, rsp_fault_o=1 the cycle after accept, remain IDLE.
REQ-020 Load: IDLE->LD_ADDR (mem_addr_o driven, mem_write_o=0)->LD_DATA (extract)->IDLE; rsp_valid_o high 3 cycles after accept cycle.
REQ-021 Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-022 SW: IDLE->ST_WR with mem_write_o=1, mem_wdata_o=req_wdata_i for exactly one cycle; rsp_valid_o 2 cycles after accept.
REQ-023 SB/SH: IDLE->RMW_ADDR (read)->RMW_DATA (merge wdata byte/half into read word at lane)->ST_WR (write merged word)->IDLE; rsp_valid_o 4 cycles after accept.
REQ-024 mem_write_o SHALL be high only in ST_WR, exactly one cycle per store; never for loads or faults.
REQ-025 Address bits [31:14] SHALL be ignored (wrap: 0x0000_4000 aliases 0x0000_0000).
REQ-026 rsp_valid_o SHALL be a single-cycle pulse, coincident with FSM return to IDLE (req_ready_o=1 same cycle); back-to-back requests accepted that cycle.
REQ-027 req_valid_i while not ready SHALL be ignored, no state change.

Reset
REQ-028 On rst_i: FSM=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_fault_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-029 Reset mid-operation SHALL abort the access: no mem_write_o in the reset cycle or after, no response issued.

Structure
REQ-030 Shared package lsu_pkg SHALL hold the funct3 width encodings, the FSM state enum, and MEM_WORDS default.
REQ-031 Byte extract/sign-extend and store merge SHALL live in one combinational sub-module lsu_align.

Verification
REQ-032 Mem word 0 = 0x8070_F0A5; LB addr 0x0 -> rsp_rdata_o=0xFFFF_FFA5; LBU addr 0x3 -> 0x0000_0080; LH addr 0x2 -> 0xFFFF_8070; each after 3 cycles.
REQ-033 Word 1 = 0x1122_3344; SB addr 0x5 wdata 0xAB -> one write, word 1 = 0x1122_AB44, rsp 4 cycles after accept.
REQ-034 LW addr 0x2 -> rsp_fault_o=1 next cycle, mem_write_o never asserted; SH addr 0x7 likewise.
REQ-035 SW addr 0x4008 wdata 0xDEAD_BEEF -> mem_addr_o=2, word 2 written; LW addr 0x8 returns 0xDEAD_BEEF.
REQ-036 rst_i asserted in RMW_DATA of SH -> no write, no rsp_valid_o, req_ready_o=1 next cycle.
REQ-037 Back-to-back SW then LW same address with req_valid_i held -> second accepted in first rsp cycle, returns stored value.
